div_sched: RTL
==============

Name: div_sched

Overview:
- Programmable tick scheduler built around a divide-by-N counter.
- Produces a base tick every `div` clocks and a toggling divided clock (`clk_n`, period 2*div).
- Shares each tick among NREQ requesters, granting one per tick in round-robin order.
- Sits between the board clock and slow consumers (display scan, debouncers, LED blink); divisor is reconfigured at run time through a valid/ready handshake.

Parameters:
- WIDTH, 32, width of divisor and counter.
- DEFAULT_DIV, 100_000, divisor loaded at reset (`clk_n` period 200_000 clocks).
- NREQ, 4, number of requesters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = counting enabled, 0 = stopped.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  WIDTH  offered divisor.
- cfg_ready  out  1  divisor can be accepted.
- cur_div  out  WIDTH  divisor currently in use.
- tick  out  1  one-cycle pulse at end of each period.
- clk_n  out  1  toggles on every tick.
- req  in  NREQ  per-requester tick request (level).
- grant  out  NREQ  one-hot, one-cycle pulse, coincident with tick.
- busy  out  1  1 while state is RUN.

Behaviour:
- Reset values: counter=0, cur_div=DEFAULT_DIV, tick=0, clk_n=0, grant=0, busy=0, cfg_ready=1, pending=0, rr pointer=0, state IDLE.
- States: IDLE, RUN.
  - IDLE -> RUN when run=1.
  - RUN -> IDLE when run=0; the same cycle clears the counter, tick and grant. clk_n holds its value.
- Counter (RUN only):
  - Increments each clock.
  - When counter==cur_div-1: counter<=0, tick=1 for that cycle, clk_n toggles.
  - First tick occurs cur_div clocks after entering RUN.
- Outputs tick, grant and clk_n are registered.
- Divisor clamp: any accepted cfg_div <2 is stored as 2. No upper clamp; the counter is WIDTH bits.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready.
  - In IDLE: cur_div updates on the next edge; counter stays 0.
  - In RUN: value goes to a pending register; pending=1 and cfg_ready=0 until the next tick boundary.
  - At the tick boundary, cur_div<=pending value and pending clears. The new period starts from 0 with the new divisor, and cfg_ready returns to 1 on the following cycle.
  - run falling while pending=1: pending is applied immediately on entry to IDLE.
- Arbitration: on each tick cycle, if req!=0, grant exactly one bit.
  - Search starts at rr pointer and proceeds upward with wrap.
  - After a grant to bit k, pointer <= (k+1) mod NREQ.
  - req=0 at tick: no grant, pointer unchanged.
  - A request must be high in the tick cycle to count. No request memory; a request missing the tick waits for the next one.
- Boundary cases:
  - cur_div=2: tick every other clock; clk_n period 4.
  - cfg accepted in the same cycle as a tick in RUN: goes to pending and is applied at the following tick, not the current one.
  - rst mid-period: all state returns to reset values immediately, regardless of clock.

Optional Feature:
- Macro: FIXED_PRIO_EN.
- Defined: the arbiter uses fixed priority, lowest index wins. The rr pointer is not implemented, and grant = lowest set bit of req at tick.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset + run=1, cur_div=DEFAULT_DIV overridden in IDLE to 4 -> tick at clocks 4, 8, 12 after RUN entry; clk_n toggles at each tick (period 8); busy=1.
- RUN with div=4, req=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001 on successive ticks, each one cycle wide, aligned with tick.
- RUN with div=5, offer cfg_div=3 two cycles after a tick -> cfg_ready falls next cycle; current period still ends at 5; subsequent ticks every 3 clocks; cfg_ready back to 1 after the boundary.
- In IDLE, cfg_div=0 and then cfg_div=1 -> cur_div reads 2 after each; RUN ticks every 2 clocks.
- RUN div=6; deassert run at count 3, reassert 2 cycles later -> no tick in between; next tick 6 clocks after re-entry; clk_n unchanged across the stop.
- Assert rst mid-period with pending=1 and req active -> cur_div=DEFAULT_DIV, pending cleared, grant=0, clk_n=0 immediately. With FIXED_PRIO_EN, req=4'b1010 -> every tick grants 0010.

Source files
------------

// File: rtl/div_sched.sv
// Divide-by-N tick scheduler: base tick, divided clock clk_n, and one grant per tick.
// Define FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module div_sched #(
  parameter int WIDTH       = 32,
  parameter int DEFAULT_DIV = 100_000,
  parameter int NREQ        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic [WIDTH-1:0] cur_div,
  output logic             tick,
  output logic             clk_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  grant,
  output logic             busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] cfg_clamped;
  logic             pending;
  logic             cfg_fire;
  logic             at_end;
  logic [NREQ-1:0]  grant_nxt;

  // Handshake: a divisor transfers on any edge where cfg_valid && cfg_ready.
  // cfg_ready is low only while a divisor waits for the next tick boundary.
  assign cfg_ready   = !pending;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign busy        = (state == S_RUN);
  assign cfg_clamped = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;
  assign at_end      = (count == cur_div - WIDTH'(1));

`ifdef FIXED_PRIO_EN
  always_comb begin
    logic found;
    grant_nxt = '0;
    found     = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        grant_nxt[j] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`else
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_nxt;

  // First pass looks at indices at or above the pointer, second pass wraps to the bottom.
  always_comb begin
    logic found;
    grant_nxt = '0;
    ptr_nxt   = rr_ptr;
    found     = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (PW'(j) >= rr_ptr)) begin
        grant_nxt[j] = 1'b1;
        ptr_nxt      = (j == NREQ - 1) ? '0 : PW'(j + 1);
        found        = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        grant_nxt[j] = 1'b1;
        ptr_nxt      = (j == NREQ - 1) ? '0 : PW'(j + 1);
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if ((state == S_RUN) && run && at_end && (|req)) begin
      rr_ptr <= ptr_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      cur_div  <= WIDTH'(DEFAULT_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      tick     <= 1'b0;
      clk_n    <= 1'b0;
      grant    <= '0;
    end else begin
      tick  <= 1'b0;
      grant <= '0;
      case (state)
        S_IDLE: begin
          count <= '0;
          if (cfg_fire) cur_div <= cfg_clamped;
          if (run) state <= S_RUN;
        end
        S_RUN: begin
          if (!run) begin
            // Stopping: any waiting divisor takes effect now rather than at a tick.
            state   <= S_IDLE;
            count   <= '0;
            pending <= 1'b0;
            if (cfg_fire) cur_div <= cfg_clamped;
            else if (pending) cur_div <= pend_div;
          end else if (at_end) begin
            count <= '0;
            tick  <= 1'b1;
            clk_n <= ~clk_n;
            grant <= grant_nxt;
            if (pending) begin
              cur_div <= pend_div;
              pending <= 1'b0;
            end else if (cfg_fire) begin
              pending  <= 1'b1;
              pend_div <= cfg_clamped;
            end
          end else begin
            count <= count + WIDTH'(1);
            if (cfg_fire) begin
              pending  <= 1'b1;
              pend_div <= cfg_clamped;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
